// File: rtl/tk1_bus_pkg.sv
// Shared definitions for the tk1 CPU bus decoder: FSM states, error bit
// positions and the default address map regions.
package tk1_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } bus_state_e;

    localparam int unsigned ERR_UNMAPPED_BIT = 0;
    localparam int unsigned ERR_TIMEOUT_BIT  = 1;

    localparam logic [31:0] ROM_BASE  = 32'h0000_0000;
    localparam logic [31:0] ROM_MASK  = 32'hC000_0000;
    localparam logic [31:0] RAM_BASE  = 32'h4000_0000;
    localparam logic [31:0] RAM_MASK  = 32'hC000_0000;
    localparam logic [31:0] MMIO_MASK = 32'hFF00_0000;
    localparam logic [7:0]  MMIO_PREFIX_FIRST = 8'hC0;
    localparam logic [7:0]  MMIO_PREFIX_LAST  = 8'hFF;

    localparam logic [31:0] ILLEGAL_INSTRUCTION = 32'h0;

    // Base address of the MMIO sub-region selected by the top address byte.
    function automatic logic [31:0] mmio_base(input logic [7:0] prefix);
        return {prefix, 24'h00_0000};
    endfunction

endpackage

// File: rtl/tk1_bus_watchdog.sv
// Saturating 16-bit access timer; flags expiry once TIMEOUT_CYCLES cycles
// of an access have elapsed.
module tk1_bus_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic reset_n,
    input  logic start,
    input  logic run,
    output logic expired
);

    localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (start) begin
            cnt_d = '0;
        end else if (run && (cnt_q != '1)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // The count holds the number of completed access cycles, so the
    // last allowed cycle sees LIMIT.
    assign expired = run && (cnt_q >= LIMIT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/tk1_bus_mux.sv
// CPU bus decoder and registered response mux for the tk1 slaves.
// Define TK1_BUS_TIMEOUT_EN to build the stalled-slave timeout.
module tk1_bus_mux
    import tk1_bus_pkg::*;
#(
    parameter int unsigned                   NUM_SLAVES     = 9,
    parameter logic [32*NUM_SLAVES-1:0]      SLV_BASE       = {NUM_SLAVES{32'h0}},
    parameter logic [32*NUM_SLAVES-1:0]      SLV_MASK       = {NUM_SLAVES{32'hffff_ffff}},
    parameter int unsigned                   TIMEOUT_CYCLES = 255,
    parameter logic [31:0]                   ERR_RDATA      = 32'h0
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       cpu_valid,
    input  logic [31:0]                cpu_addr,
    input  logic [3:0]                 cpu_wstrb,
    input  logic [31:0]                cpu_wdata,
    input  logic                       force_trap,
    output logic                       cpu_ready,
    output logic [31:0]                cpu_rdata,
    output logic [NUM_SLAVES-1:0]      slv_cs,
    output logic                       slv_we,
    output logic [3:0]                 slv_wstrb,
    output logic [31:0]                slv_wdata,
    output logic [31:0]                slv_addr,
    input  logic [32*NUM_SLAVES-1:0]   slv_rdata,
    input  logic [NUM_SLAVES-1:0]      slv_ready,
    input  logic                       err_clear,
    output logic [1:0]                 err_status,
    output logic [31:0]                err_addr
);

    localparam int unsigned SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

    bus_state_e            state_q, state_d;
    logic [SEL_W-1:0]      sel_q, sel_d;
    logic [31:0]           rdata_q, rdata_d;
    logic [1:0]            err_status_q, err_status_d;
    logic [31:0]           err_addr_q, err_addr_d;
    logic [1:0]            new_err;
    logic                  hit;
    logic [SEL_W-1:0]      hit_idx;
    logic [NUM_SLAVES-1:0] cs;
    logic                  wd_start, wd_run, wd_expired;

    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            if (!hit && ((cpu_addr & SLV_MASK[32*i +: 32]) == SLV_BASE[32*i +: 32])) begin
                hit     = 1'b1;
                hit_idx = SEL_W'(i);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        rdata_d  = rdata_q;
        cs       = '0;
        new_err  = '0;
        wd_start = 1'b0;
        wd_run   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cpu_valid) begin
                    if (force_trap) begin
                        state_d = ST_RESP;
                        rdata_d = ERR_RDATA;
                    end else if (!hit) begin
                        state_d = ST_RESP;
                        rdata_d = ERR_RDATA;
                        new_err[ERR_UNMAPPED_BIT] = 1'b1;
                    end else begin
                        state_d     = ST_ACCESS;
                        sel_d       = hit_idx;
                        cs[hit_idx] = 1'b1;
                        wd_start    = 1'b1;
                    end
                end
            end
            ST_ACCESS: begin
                cs[sel_q] = 1'b1;
                wd_run    = 1'b1;
                // Ready wins over a coincident expiry.
                if (slv_ready[sel_q]) begin
                    state_d = ST_RESP;
                    rdata_d = slv_rdata[32*int'(sel_q) +: 32];
                end else if (wd_expired) begin
                    state_d = ST_RESP;
                    rdata_d = ERR_RDATA;
                    new_err[ERR_TIMEOUT_BIT] = 1'b1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        err_status_d = err_status_q;
        err_addr_d   = err_addr_q;
        if (err_clear) begin
            err_status_d = '0;
            err_addr_d   = '0;
        end else if (new_err != '0) begin
            err_status_d = err_status_q | new_err;
            if (err_status_q == '0) begin
                err_addr_d = cpu_addr;
            end
        end
    end

`ifdef TK1_BUS_TIMEOUT_EN
    tk1_bus_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (wd_start),
        .run     (wd_run),
        .expired (wd_expired)
    );
`else
    logic unused_wd;
    assign unused_wd  = ^{wd_start, wd_run, TIMEOUT_CYCLES[0]};
    assign wd_expired = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            sel_q        <= '0;
            rdata_q      <= '0;
            err_status_q <= '0;
            err_addr_q   <= '0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            rdata_q      <= rdata_d;
            err_status_q <= err_status_d;
            err_addr_q   <= err_addr_d;
        end
    end

    // Gated by reset so a request still held during reset cannot select a slave.
    assign slv_cs     = reset_n ? cs : '0;
    assign cpu_ready  = (state_q == ST_RESP);
    assign cpu_rdata  = rdata_q;
    assign slv_we     = |cpu_wstrb;
    assign slv_wstrb  = cpu_wstrb;
    assign slv_wdata  = cpu_wdata;
    assign slv_addr   = cpu_addr;
    assign err_status = err_status_q;
    assign err_addr   = err_addr_q;

endmodule

// File: tb/tb_tk1_bus_mux.sv
// Directed self-checking bench for tk1_bus_mux with a nine-slave map
// (slaves 2 and 5 overlap in the 0xC0 region).
module tb_tk1_bus_mux;

    localparam int unsigned NS = 9;
    localparam logic [32*NS-1:0] BASES = {
        32'hF000_0000, 32'hE000_0000, 32'hD000_0000, 32'hC000_0000, 32'hC200_0000,
        32'hC100_0000, 32'hC000_0000, 32'h4000_0000, 32'h0000_0000};
    localparam logic [32*NS-1:0] MASKS = {
        32'hFF00_0000, 32'hFF00_0000, 32'hFF00_0000, 32'hF000_0000, 32'hFF00_0000,
        32'hFF00_0000, 32'hFF00_0000, 32'hC000_0000, 32'hC000_0000};

    logic              clk = 1'b0;
    logic              reset_n;
    logic              cpu_valid;
    logic [31:0]       cpu_addr;
    logic [3:0]        cpu_wstrb;
    logic [31:0]       cpu_wdata;
    logic              force_trap;
    logic              cpu_ready;
    logic [31:0]       cpu_rdata;
    logic [NS-1:0]     slv_cs;
    logic              slv_we;
    logic [3:0]        slv_wstrb;
    logic [31:0]       slv_wdata;
    logic [31:0]       slv_addr;
    logic [32*NS-1:0]  slv_rdata;
    logic [NS-1:0]     slv_ready;
    logic              err_clear;
    logic [1:0]        err_status;
    logic [31:0]       err_addr;

    int checks   = 0;
    int failures = 0;

    tk1_bus_mux #(
        .NUM_SLAVES     (NS),
        .SLV_BASE       (BASES),
        .SLV_MASK       (MASKS),
        .TIMEOUT_CYCLES (4),
        .ERR_RDATA      (32'h0)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cpu_valid  (cpu_valid),
        .cpu_addr   (cpu_addr),
        .cpu_wstrb  (cpu_wstrb),
        .cpu_wdata  (cpu_wdata),
        .force_trap (force_trap),
        .cpu_ready  (cpu_ready),
        .cpu_rdata  (cpu_rdata),
        .slv_cs     (slv_cs),
        .slv_we     (slv_we),
        .slv_wstrb  (slv_wstrb),
        .slv_wdata  (slv_wdata),
        .slv_addr   (slv_addr),
        .slv_rdata  (slv_rdata),
        .slv_ready  (slv_ready),
        .err_clear  (err_clear),
        .err_status (err_status),
        .err_addr   (err_addr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [31:0] addr, input logic [3:0] strb, input logic trap);
        cpu_valid  = 1'b1;
        cpu_addr   = addr;
        cpu_wstrb  = strb;
        cpu_wdata  = 32'hA5A5_0000 ^ addr;
        force_trap = trap;
    endtask

    task automatic drop();
        cpu_valid  = 1'b0;
        force_trap = 1'b0;
        cpu_wstrb  = 4'h0;
    endtask

    // Slave read with ready in cycle 1, response in cycle 2.
    task automatic read_k1(input string tag, input logic [31:0] addr, input int unsigned idx,
                           input logic [31:0] exp_data);
        tick(); req(addr, 4'h0, 1'b0); #1;
        chk({tag, "_cs0"}, 32'(slv_cs), 32'(1) << idx);
        tick(); slv_ready = NS'(1) << idx; #1;
        chk({tag, "_cs1"}, 32'(slv_cs), 32'(1) << idx);
        chk({tag, "_rdy1"}, 32'(cpu_ready), 32'h0);
        tick(); slv_ready = '0; drop(); #1;
        chk({tag, "_rdy2"}, 32'(cpu_ready), 32'h1);
        chk({tag, "_data"}, cpu_rdata, exp_data);
        chk({tag, "_cs2"}, 32'(slv_cs), 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: observed stuck expected finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        reset_n = 1'b0; err_clear = 1'b0; slv_ready = '0;
        drop(); cpu_addr = '0; cpu_wdata = '0;
        for (int i = 0; i < int'(NS); i++) slv_rdata[32*i +: 32] = 32'h1000_0000 + 32'(i);
        slv_rdata[63:32] = 32'hDEAD_BEEF;

        // Reset state, with a hit request held during reset.
        tick(); req(32'h4000_0010, 4'h0, 1'b0); #1;
        chk("rst_cs", 32'(slv_cs), 32'h0);
        chk("rst_ready", 32'(cpu_ready), 32'h0);
        chk("rst_rdata", cpu_rdata, 32'h0);
        chk("rst_err", 32'(err_status), 32'h0);
        chk("rst_eaddr", err_addr, 32'h0);
        drop(); #2; reset_n = 1'b1;

        read_k1("ram", 32'h4000_0010, 1, 32'hDEAD_BEEF);

        // Unmapped write.
        tick(); req(32'h8000_0000, 4'hF, 1'b0); #1;
        chk("unm_cs", 32'(slv_cs), 32'h0);
        chk("unm_we", 32'(slv_we), 32'h1);
        chk("unm_wstrb", 32'(slv_wstrb), 32'hF);
        chk("unm_wdata", slv_wdata, 32'h25A5_0000);
        chk("unm_addr", slv_addr, 32'h8000_0000);
        tick(); drop(); #1;
        chk("unm_ready", 32'(cpu_ready), 32'h1);
        chk("unm_rdata", cpu_rdata, 32'h0);
        chk("unm_err", 32'(err_status), 32'h1);
        chk("unm_eaddr", err_addr, 32'h8000_0000);

        tick(); err_clear = 1'b1;
        tick(); err_clear = 1'b0; #1;
        chk("clr_err", 32'(err_status), 32'h0);
        chk("clr_eaddr", err_addr, 32'h0);

        // Overlap: slaves 2 and 5 both decode 0xC000_0004; foreign ready ignored.
        tick(); req(32'hC000_0004, 4'h0, 1'b0); #1;
        chk("ovl_cs0", 32'(slv_cs), 32'h004);
        tick(); slv_ready = 9'h1FB; #1;
        chk("ovl_cs1", 32'(slv_cs), 32'h004);
        tick(); slv_ready = 9'h004; #1;
        chk("ovl_rdy2", 32'(cpu_ready), 32'h0);
        chk("ovl_cs2", 32'(slv_cs), 32'h004);
        tick(); slv_ready = '0; drop(); #1;
        chk("ovl_rdy3", 32'(cpu_ready), 32'h1);
        chk("ovl_data", cpu_rdata, 32'h1000_0002);

        // Stalled slave 3.
        tick(); req(32'hC100_0000, 4'h0, 1'b0); #1;
        chk("to_cs0", 32'(slv_cs), 32'h008);
`ifdef TK1_BUS_TIMEOUT_EN
        for (int c = 1; c <= 4; c++) begin
            tick(); #1;
            chk("to_cs", 32'(slv_cs), 32'h008);
            chk("to_wait", 32'(cpu_ready), 32'h0);
        end
        tick(); drop(); #1;
        chk("to_ready", 32'(cpu_ready), 32'h1);
        chk("to_rdata", cpu_rdata, 32'h0);
        chk("to_err", 32'(err_status), 32'h2);
        chk("to_eaddr", err_addr, 32'hC100_0000);

        // Ready in the expiry cycle is a success.
        tick(); req(32'hC200_0000, 4'h0, 1'b0);
        for (int c = 1; c <= 3; c++) tick();
        tick(); slv_ready = 9'h010;
        tick(); slv_ready = '0; drop(); #1;
        chk("edge_ready", 32'(cpu_ready), 32'h1);
        chk("edge_data", cpu_rdata, 32'h1000_0004);
        chk("edge_err", 32'(err_status), 32'h2);
`else
        for (int c = 1; c <= 6; c++) begin
            tick(); #1;
            chk("to_cs", 32'(slv_cs), 32'h008);
            chk("to_wait", 32'(cpu_ready), 32'h0);
        end
        tick(); slv_ready = 9'h008;
        tick(); slv_ready = '0; drop(); #1;
        chk("to_ready", 32'(cpu_ready), 32'h1);
        chk("to_rdata", cpu_rdata, 32'h1000_0003);
        chk("to_err", 32'(err_status), 32'h0);
`endif

        tick(); req(32'h8000_0004, 4'h0, 1'b0);
        tick(); drop(); #1;
        chk("unm2_ready", 32'(cpu_ready), 32'h1);
`ifdef TK1_BUS_TIMEOUT_EN
        chk("unm2_err", 32'(err_status), 32'h3);
        chk("unm2_eaddr", err_addr, 32'hC100_0000);
`else
        chk("unm2_err", 32'(err_status), 32'h1);
        chk("unm2_eaddr", err_addr, 32'h8000_0004);
`endif

        // New error coincident with clear is dropped.
        tick(); req(32'h8000_0008, 4'h0, 1'b0); err_clear = 1'b1;
        tick(); err_clear = 1'b0; drop(); #1;
        chk("clr2_ready", 32'(cpu_ready), 32'h1);
        chk("clr2_err", 32'(err_status), 32'h0);
        chk("clr2_eaddr", err_addr, 32'h0);

        read_k1("s7", 32'hE000_0000, 7, 32'h1000_0007);

        // Forced trap on a mapped address.
        tick(); req(32'h4000_0000, 4'h0, 1'b1); #1;
        chk("trap_cs0", 32'(slv_cs), 32'h0);
        tick(); drop(); #1;
        chk("trap_ready", 32'(cpu_ready), 32'h1);
        chk("trap_rdata", cpu_rdata, 32'h0);
        chk("trap_cs1", 32'(slv_cs), 32'h0);
        chk("trap_err", 32'(err_status), 32'h0);

        // Reset in the middle of an access.
        tick(); req(32'h9000_0000, 4'h0, 1'b0);
        tick(); drop();
        read_k1("pre", 32'h4000_0020, 1, 32'hDEAD_BEEF);
        chk("pre_err", 32'(err_status), 32'h1);
        tick(); req(32'hE000_0000, 4'h0, 1'b0);
        tick(); #1;
        chk("mid_cs", 32'(slv_cs), 32'h080);
        #2; reset_n = 1'b0; #1;
        chk("mid_cs_rst", 32'(slv_cs), 32'h0);
        chk("mid_ready", 32'(cpu_ready), 32'h0);
        chk("mid_rdata", cpu_rdata, 32'h0);
        chk("mid_err", 32'(err_status), 32'h0);
        chk("mid_eaddr", err_addr, 32'h0);
        drop(); #1; reset_n = 1'b1;
        read_k1("post", 32'h4000_0010, 1, 32'hDEAD_BEEF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
